meter_peak_hold: RTL
====================

Name: meter_peak_hold

Overview:
- Sits directly downstream of the DSP memory interface's metering write port (meter_wr_data/addr/en, upper-half IO addresses).
- Holds a per-channel peak absolute value for NUM_METERS meter slots and serves them to the CPU through a read-and-clear port, so the host can poll meters at any rate without missing transients.
- Storage is inferred RAM or registers (implementer's choice); only the observable behaviour below is specified.

Parameters:
- IO_WIDTH, 24, width of signed meter samples from the DSP.
- METER_ADDR_WIDTH, 8, meter slot address width.
- NUM_METERS, 256, number of slots; must equal 2**METER_ADDR_WIDTH.

Ports:
- clk  in  1  system (CPU) clock
- reset  in  1  synchronous, active-high reset
- meter_wr_data  in  IO_WIDTH  signed two's-complement sample from DSP
- meter_wr_addr  in  METER_ADDR_WIDTH  meter slot
- meter_wr_en  in  1  sample valid this cycle
- cpu_rd_addr  in  METER_ADDR_WIDTH  slot to read
- cpu_rd_en  in  1  read request, one per cycle allowed
- cpu_rd_clear  in  1  qualifies cpu_rd_en: zero the slot after reading
- cpu_rd_data  out  IO_WIDTH-1  peak magnitude (unsigned)
- cpu_rd_valid  out  1  cpu_rd_data valid this cycle
- cpu_rd_clip  out  1  sticky clip flag for slot (see Optional Feature)
- busy  out  1  high while the post-reset clear sweep runs

Behaviour:
- Reset: all outputs 0 on the cycle after reset is sampled high; FSM enters CLEAR; busy=1.
- FSM states:
  - CLEAR: writes 0 (peak and clip) to slot 0..NUM_METERS-1, one per cycle; exits to RUN after the last slot. busy=1 for exactly NUM_METERS cycles after reset deasserts.
  - RUN: busy=0.
- Reset asserted in any state restarts CLEAR from slot 0.
- During CLEAR: meter_wr_en and cpu_rd_en are ignored; cpu_rd_valid stays 0.
- Magnitude: mag = |meter_wr_data|, IO_WIDTH-1 bits unsigned; the most-negative input (-2^(IO_WIDTH-1)) saturates to 2^(IO_WIDTH-1)-1.
- Update: each accepted meter write sets peak[a] = max(peak[a], mag). This is a 2-stage read-modify-write; back-to-back writes to the same slot must forward, so no update is lost at one write per cycle.
- CPU read latency: cpu_rd_en in cycle N gives cpu_rd_valid=1 and cpu_rd_data in cycle N+2, for one cycle. Reads are fully pipelined.
- Read value includes every meter write with meter_wr_en high in cycles <= N-1 to that slot. It excludes writes in cycle N or later.
- Read-and-clear (cpu_rd_clear=1 with cpu_rd_en):
  - The slot becomes 0 after the read, except that meter writes to the same slot in cycles >= N are retained, so the slot becomes max of those magnitudes.
  - No sample is ever lost across a clear.
- A read without clear leaves the slot unchanged.
- Reads and meter writes to the same or different slots in the same cycle are always legal; there is no backpressure on either side.
- A peak of 0 is a legitimate value (silence), not an error.

Optional Feature:
- Macro: METER_CLIP_DETECT_EN.
- Defined:
  - Each slot holds a sticky clip bit, set when an accepted write has mag == 2^(IO_WIDTH-1)-1 (including the saturated most-negative input).
  - Returned on cpu_rd_clip alongside cpu_rd_data, with the same latency and the same include/exclude and clear/retain rules as the peak.
- Undefined: no clip storage; cpu_rd_clip is constant 0.

Test Plan:
- Post-reset sweep: pulse reset 1 cycle -> busy=1 for 256 cycles, then 0; a read of any slot (e.g. slot 0x7F) returns 0 with valid at N+2. A cpu_rd_en issued during busy produces no valid.
- Peak tracking: writes to slot 0x80 of 0x000100, 0xFFF000 (-4096), 0x000800 on consecutive cycles, then read -> cpu_rd_data 0x001000.
- Saturation/clip: write 0x800000 to slot 0x03, then read -> data 0x7FFFFF; clip=1 with METER_CLIP_DETECT_EN, 0 without. Writing 0x7FFFFE instead -> clip=0.
- Read-and-clear collision: slot 0x10 holds 0x000200; in cycle N issue read+clear and a meter write of 0x000050 to 0x10 -> read returns 0x000200; a following read returns 0x000050.
- Plain read with no clear: two reads of slot 0x10 -> identical values; slot unchanged.
- Reset mid-operation: with slot 0x22 = 0x123456, assert reset while a read is in flight -> no valid pulse from that read; busy sweep restarts; afterwards slot 0x22 reads 0.

Source files
------------

// File: rtl/meter_peak_hold_if.sv
// Meter write / CPU read bus between the DSP meter port, the CPU and meter_peak_hold.
// master: DSP+CPU side drives writes and reads; slave: the peak-hold block returns data, valid, clip, busy.
interface meter_peak_hold_if #(
    parameter int IO_WIDTH         = 24,
    parameter int METER_ADDR_WIDTH = 8
);
    logic [IO_WIDTH-1:0]         meter_wr_data;
    logic [METER_ADDR_WIDTH-1:0] meter_wr_addr;
    logic                        meter_wr_en;
    logic [METER_ADDR_WIDTH-1:0] cpu_rd_addr;
    logic                        cpu_rd_en;
    logic                        cpu_rd_clear;
    logic [IO_WIDTH-2:0]         cpu_rd_data;
    logic                        cpu_rd_valid;
    logic                        cpu_rd_clip;
    logic                        busy;

    modport master (
        output meter_wr_data, meter_wr_addr, meter_wr_en,
        output cpu_rd_addr, cpu_rd_en, cpu_rd_clear,
        input  cpu_rd_data, cpu_rd_valid, cpu_rd_clip, busy
    );

    modport slave (
        input  meter_wr_data, meter_wr_addr, meter_wr_en,
        input  cpu_rd_addr, cpu_rd_en, cpu_rd_clear,
        output cpu_rd_data, cpu_rd_valid, cpu_rd_clip, busy
    );
endinterface

// File: rtl/meter_peak_hold.sv
// Per-slot peak-magnitude hold with CPU read-and-clear port and post-reset clear sweep.
// Ports: clk, reset (sync, active-high), bus (meter_peak_hold_if.slave). Option: METER_CLIP_DETECT_EN.
module meter_peak_hold #(
    parameter int IO_WIDTH         = 24,
    parameter int METER_ADDR_WIDTH = 8,
    parameter int NUM_METERS       = 256
) (
    input  logic               clk,
    input  logic               reset,
    meter_peak_hold_if.slave   bus
);
    localparam int MW = IO_WIDTH - 1;
    localparam int AW = METER_ADDR_WIDTH;
    localparam logic [AW-1:0] LAST = AW'(NUM_METERS - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t        state;
    logic [AW-1:0] sweep;
    logic          busy_q;
    logic          s1_valid;
    logic [MW-1:0] s1_data;
    logic          rd_valid_q;
    logic [MW-1:0] rd_data_q;

    // Flop storage: the read-modify-write resolves within one cycle, so
    // back-to-back writes to one slot always see the previous update.
    logic [MW-1:0] peak [NUM_METERS];

    logic [IO_WIDTH-1:0] raw;
    logic [IO_WIDTH-1:0] neg;
    logic [MW-1:0]       mag;
    logic [MW-1:0]       upd;
    logic                clr_hit;
    logic                run;
    logic                sweep_wr;

    assign run      = (state == RUN) && !reset;
    assign sweep_wr = (state == CLEAR) && !reset;

    always_comb begin
        raw = bus.meter_wr_data;
        neg = ~raw + IO_WIDTH'(1);
        mag = raw[IO_WIDTH-1] ? neg[MW-1:0] : raw[MW-1:0];
        // Only the most-negative input leaves the MSB set after negation.
        if (raw[IO_WIDTH-1] && neg[IO_WIDTH-1]) begin
            mag = '1;
        end
    end

    // A clear in the same cycle as a write to that slot keeps only the new sample.
    assign clr_hit = bus.cpu_rd_en && bus.cpu_rd_clear &&
                     (bus.cpu_rd_addr == bus.meter_wr_addr);

    always_comb begin
        upd = mag;
        if (!clr_hit && (peak[bus.meter_wr_addr] > mag)) begin
            upd = peak[bus.meter_wr_addr];
        end
    end

    // Write is ordered after the clear so a colliding sample survives.
    always_ff @(posedge clk) begin
        if (sweep_wr) begin
            peak[sweep] <= '0;
        end else if (run) begin
            if (bus.cpu_rd_en && bus.cpu_rd_clear) begin
                peak[bus.cpu_rd_addr] <= '0;
            end
            if (bus.meter_wr_en) begin
                peak[bus.meter_wr_addr] <= upd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLEAR;
            sweep      <= '0;
            busy_q     <= 1'b1;
            s1_valid   <= 1'b0;
            s1_data    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            unique case (state)
                CLEAR: begin
                    sweep <= sweep + AW'(1);
                    if (sweep == LAST) begin
                        state  <= RUN;
                        busy_q <= 1'b0;
                    end
                end
                RUN: begin
                end
            endcase
            s1_valid   <= (state == RUN) && bus.cpu_rd_en;
            s1_data    <= peak[bus.cpu_rd_addr];
            rd_valid_q <= s1_valid;
            rd_data_q  <= s1_data;
        end
    end

    assign bus.cpu_rd_data  = rd_data_q;
    assign bus.cpu_rd_valid = rd_valid_q;
    assign bus.busy         = busy_q;

`ifdef METER_CLIP_DETECT_EN
    logic clip [NUM_METERS];
    logic wr_full;
    logic clip_upd;
    logic s1_clip;
    logic rd_clip_q;

    assign wr_full  = (mag == '1);
    assign clip_upd = (clr_hit ? 1'b0 : clip[bus.meter_wr_addr]) | wr_full;

    always_ff @(posedge clk) begin
        if (sweep_wr) begin
            clip[sweep] <= 1'b0;
        end else if (run) begin
            if (bus.cpu_rd_en && bus.cpu_rd_clear) begin
                clip[bus.cpu_rd_addr] <= 1'b0;
            end
            if (bus.meter_wr_en) begin
                clip[bus.meter_wr_addr] <= clip_upd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_clip   <= 1'b0;
            rd_clip_q <= 1'b0;
        end else begin
            s1_clip   <= clip[bus.cpu_rd_addr];
            rd_clip_q <= s1_clip;
        end
    end

    assign bus.cpu_rd_clip = rd_clip_q;
`else
    assign bus.cpu_rd_clip = 1'b0;
`endif
endmodule
